// File: rtl/bi_mem_tp_pipe.sv
// Two-port (1R/1W) single-clock memory with byte-lane write mask, pipelined valid-tagged reads,
// selectable read-during-write policy and an optional post-reset clear sweep.
module bi_mem_tp_pipe #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned HEIGHT         = 64,
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned WRITE_FIRST    = 1,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    output logic                          ready_o,
    input  logic                          readEnable_i,
    input  logic [$clog2(HEIGHT)-1:0]     readAddr_i,
    output logic [WIDTH-1:0]              readData_o,
    output logic                          readValid_o,
    input  logic                          writeEnable_i,
    input  logic [$clog2(HEIGHT)-1:0]     writeAddr_i,
    input  logic [WIDTH/BYTE_WIDTH-1:0]   writeMask_i,
    input  logic [WIDTH-1:0]              writeData_i
);

    localparam int unsigned AW     = $clog2(HEIGHT);
    localparam int unsigned MASK_W = WIDTH / BYTE_WIDTH;
    localparam int unsigned LAT    = READ_LATENCY;

    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            ready_q, ready_d;
    logic            clr_we;

    logic [WIDTH-1:0] mem_q [HEIGHT];

    logic             rd_acc, wr_acc, rd_in_range, wr_in_range, collide;
    logic [WIDTH-1:0] wr_bits, old_word, merged_word, rd_word;

    logic [LAT-1:0]   vld_q;
    logic [WIDTH-1:0] dat_q [LAT];

    // State register: clear sweep restarts from word 0 on every reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt_q <= '0;
            ready_q   <= (CLEAR_ON_RESET == 0);
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clr_cnt_q == AW'(HEIGHT - 1)) state_d = ST_RUN;
            default:  state_d = state_q;
        endcase
    end

    // Output decode: one cleared word per cycle, ready follows entry into RUN
    always_comb begin
        clr_we    = 1'b0;
        clr_cnt_d = clr_cnt_q;
        ready_d   = (state_d == ST_RUN);
        if (state_q == ST_CLEAR) begin
            clr_we    = 1'b1;
            clr_cnt_d = clr_cnt_q + AW'(1);
        end
    end

    always_comb begin
        wr_bits = '0;
        for (int k = 0; k < MASK_W; k++) begin
            wr_bits[k*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{writeMask_i[k]}};
        end
    end

    // Port acceptance and read-during-write merge
    always_comb begin
        rd_in_range = {1'b0, readAddr_i}  < (AW+1)'(HEIGHT);
        wr_in_range = {1'b0, writeAddr_i} < (AW+1)'(HEIGHT);
        rd_acc      = readEnable_i & ready_q;
        wr_acc      = writeEnable_i & ready_q & wr_in_range & (|writeMask_i);
        old_word    = rd_in_range ? mem_q[readAddr_i] : '0;
        merged_word = (old_word & ~wr_bits) | (writeData_i & wr_bits);
        collide     = (WRITE_FIRST != 0) && wr_acc && (writeAddr_i == readAddr_i);
        rd_word     = collide ? merged_word : old_word;
    end

    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_acc) begin
            mem_q[writeAddr_i] <= (mem_q[writeAddr_i] & ~wr_bits) | (writeData_i & wr_bits);
        end
    end

    // Read pipeline; each data stage only advances with its valid so the output holds
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) dat_q[i] <= '0;
        end else begin
            vld_q[0] <= rd_acc;
            if (rd_acc) dat_q[0] <= rd_word;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign ready_o     = ready_q;
    assign readValid_o = vld_q[LAT-1];
    assign readData_o  = dat_q[LAT-1];

endmodule
